command_router: RTL

- Parametrised successor of the single-channel command forwarder.
- Accepts variable-length commands from the IPbus-side stream and buffers each complete command.
- Prepends a per-destination command sequence number (CSN) and forwards the packet to the shared channel TX FIFO interface.
- Sits between the IPbus command register block and the per-channel TX FIFOs. Adds destination validation, overflow protection and independent CSN counters per channel.

---
 rtl/command_router.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/command_router.sv
// Command router: buffers each complete IPbus command, then forwards it to the
// channel TX FIFOs as a packet headed by that destination's sequence number.

module command_router_csn #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   output logic [DATA_W-1:0] csn
);
   localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

   // Plain binary add wraps to zero after the all-ones value.
   always_ff @(posedge clk) begin
      if (rst)      csn <= '0;
      else if (inc) csn <= csn + ONE;
   end
endmodule

module command_router #(
   parameter int DATA_W    = 32,
   parameter int DEST_W    = 4,
   parameter int NUM_CHAN  = 5,
   parameter int MAX_WORDS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] ipbus_data,
   input  logic [DEST_W-1:0] ipbus_dest,
   input  logic              ipbus_last,
   input  logic              ipbus_valid,
   output logic              ipbus_ready,
   output logic [DATA_W-1:0] chan_tx_fifo_data,
   output logic [DEST_W-1:0] chan_tx_fifo_dest,
   output logic              chan_tx_fifo_last,
   output logic              chan_tx_fifo_valid,
   input  logic              chan_tx_fifo_ready,
   output logic              err_bad_dest,
   output logic              err_overflow,
   output logic              busy
);
   localparam int CNT_W = $clog2(MAX_WORDS + 1);
   localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(MAX_WORDS);
   localparam logic [DEST_W:0]   CHAN_LIM = (DEST_W + 1)'(NUM_CHAN);

   typedef enum logic [2:0] {
      IDLE, CAPTURE, DROP, SEND_CSN, SEND_DATA
   } state_t;

   state_t                          state, state_nxt;
   logic [DATA_W-1:0]               buffer [MAX_WORDS];
   logic [CNT_W-1:0]                count, rd;
   logic [DEST_W-1:0]               dest_q;
   logic                            drop_bad;
   logic [NUM_CHAN-1:0][DATA_W-1:0] csn;
   logic [NUM_CHAN-1:0]             csn_inc;
   logic [DATA_W-1:0]               csn_cur;
   logic                            in_fire, out_fire, dest_bad, buf_full, rd_last;

   assign in_fire  = ipbus_valid & ipbus_ready;
   assign out_fire = chan_tx_fifo_valid & chan_tx_fifo_ready;
   // Extra top bit keeps the compare correct when NUM_CHAN == 2**DEST_W.
   assign dest_bad = {1'b0, ipbus_dest} >= CHAN_LIM;
   assign buf_full = (count == FULL_CNT);
   assign rd_last  = (rd == count - ONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (in_fire) begin
               if (dest_bad)        state_nxt = ipbus_last ? IDLE : DROP;
               else if (ipbus_last) state_nxt = SEND_CSN;
               else                 state_nxt = CAPTURE;
            end
         CAPTURE:
            if (in_fire) begin
               if (buf_full)        state_nxt = ipbus_last ? IDLE : DROP;
               else if (ipbus_last) state_nxt = SEND_CSN;
            end
         DROP:
            if (in_fire && ipbus_last) state_nxt = IDLE;
         SEND_CSN:
            if (out_fire) state_nxt = SEND_DATA;
         SEND_DATA:
            if (out_fire && rd_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ipbus_ready        = 1'b0;
      chan_tx_fifo_valid = 1'b0;
      chan_tx_fifo_last  = 1'b0;
      chan_tx_fifo_data  = '0;
      busy               = (state != IDLE);
      unique case (state)
         IDLE, CAPTURE, DROP: ipbus_ready = 1'b1;
         SEND_CSN: begin
            chan_tx_fifo_valid = 1'b1;
            chan_tx_fifo_data  = csn_cur;
         end
         SEND_DATA: begin
            chan_tx_fifo_valid = 1'b1;
            chan_tx_fifo_data  = buffer[rd[IDX_W-1:0]];
            chan_tx_fifo_last  = rd_last;
         end
         default: ;
      endcase
   end

   assign chan_tx_fifo_dest = dest_q;

   always_comb begin
      csn_cur = '0;
      for (int c = 0; c < NUM_CHAN; c++)
         if (dest_q == DEST_W'(c)) csn_cur = csn[c];
   end

   for (genvar c = 0; c < NUM_CHAN; c++) begin : g_csn
      assign csn_inc[c] = (state == SEND_DATA) && out_fire && rd_last &&
                          (dest_q == DEST_W'(c));
      command_router_csn #(.DATA_W(DATA_W)) u_csn (
         .clk (clk),
         .rst (rst),
         .inc (csn_inc[c]),
         .csn (csn[c])
      );
   end

   // Payload storage needs no reset; count gates what is ever read.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         if (state == IDLE)
            buffer[0] <= ipbus_data;
         else if (state == CAPTURE && !buf_full)
            buffer[count[IDX_W-1:0]] <= ipbus_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count        <= '0;
         rd           <= '0;
         dest_q       <= '0;
         drop_bad     <= 1'b0;
         err_bad_dest <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         err_bad_dest <= 1'b0;
         err_overflow <= 1'b0;
         unique case (state)
            IDLE:
               if (in_fire) begin
                  dest_q       <= ipbus_dest;
                  count        <= ONE;
                  drop_bad     <= dest_bad;
                  err_bad_dest <= dest_bad & ipbus_last;
               end
            CAPTURE:
               if (in_fire) begin
                  if (buf_full) begin
                     drop_bad     <= 1'b0;
                     err_overflow <= ipbus_last;
                  end else begin
                     count <= count + ONE;
                  end
               end
            DROP:
               if (in_fire && ipbus_last) begin
                  err_bad_dest <= drop_bad;
                  err_overflow <= !drop_bad;
               end
            SEND_CSN:
               if (out_fire) rd <= '0;
            SEND_DATA:
               if (out_fire) begin
                  if (rd_last) begin
                     count <= '0;
                     rd    <= '0;
                  end else begin
                     rd <= rd + ONE;
                  end
               end
            default: ;
         endcase
      end
   end
endmodule
